// File: rtl/vga_tile_painter.sv
// ---------------------------------------------------------------------------
// vga_tile_painter
// Paints a 16x16 grid of coloured tiles inside a bordered active area of a
// VGA raster, with a blinking cursor tile and a bulk-clear engine.
//
// Ports
//   Clock            : the only clock
//   Reset            : asynchronous, active-high
//   iCont_X/iCont_Y  : raster counters from the sync generator
//   iH_Sync/iV_Sync  : syncs from the sync generator
//   iCursorX/Y       : cursor tile column / row
//   iWrValid/iWrAddr/iWrData/oWrReady : tile write port ({row,col} address)
//   iClear           : one-cycle pulse that starts a full clear
//   oBusy            : clear in progress
//   oRGB             : pixel colour, two cycles after iCont_X/iCont_Y
//   oH_Sync/oV_Sync  : syncs delayed by two cycles to stay aligned with oRGB
// ---------------------------------------------------------------------------
module vga_tile_painter #(
    parameter int         BORDER_X     = 48,
    parameter int         BORDER_Y     = 32,
    parameter int         TILE_W       = 40,
    parameter int         TILE_H       = 30,
    parameter logic [2:0] BORDER_RGB   = 3'b010,
    parameter logic [2:0] CLEAR_RGB    = 3'b000,
    parameter logic [2:0] CURSOR_RGB   = 3'b111,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] iCont_X,
    input  logic [9:0] iCont_Y,
    input  logic       iH_Sync,
    input  logic       iV_Sync,
    input  logic [3:0] iCursorX,
    input  logic [3:0] iCursorY,
    input  logic       iWrValid,
    input  logic [7:0] iWrAddr,
    input  logic [2:0] iWrData,
    output logic       oWrReady,
    input  logic       iClear,
    output logic       oBusy,
    output logic [2:0] oRGB,
    output logic       oH_Sync,
    output logic       oV_Sync
);

    localparam logic [9:0] X_BEG = 10'(BORDER_X);
    localparam logic [9:0] X_END = 10'(BORDER_X + 16 * TILE_W);
    localparam logic [9:0] Y_BEG = 10'(BORDER_Y);
    localparam logic [9:0] Y_END = 10'(BORDER_Y + 16 * TILE_H);
    localparam int         FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Control state
    state_t          state_q;
    logic [7:0]      clr_addr_q;

    // Pixel pipeline stage 1
    logic            active_q;
    logic [3:0]      col_q;
    logic [3:0]      row_q;
    logic [3:0]      cur_x_q;
    logic [3:0]      cur_y_q;
    logic [2:0]      tile_q;
    logic            hs1_q;
    logic            vs1_q;

    // Pixel pipeline stage 2 / outputs
    logic [2:0]      rgb_q;
    logic            hs2_q;
    logic            vs2_q;

    // Blink timing
    logic [FC_W-1:0] frame_q;
    logic            visible_q;

    // Combinational helpers
    logic [9:0]      x_off_s;
    logic [9:0]      y_off_s;
    logic            active_s;
    logic [3:0]      col_s;
    logic [3:0]      row_s;
    logic            hit_s;
    logic            tick_s;
    logic [2:0]      rgb_d;
    logic            wr_ready_s;
    logic            wr_en_s;
    logic [7:0]      wr_addr_s;
    logic [2:0]      wr_data_s;

    logic [2:0]      tile_mem [0:255];

    // Tile column/row via compare chains against constant tile boundaries
    always_comb begin
        x_off_s  = iCont_X - X_BEG;
        y_off_s  = iCont_Y - Y_BEG;
        active_s = (iCont_X >= X_BEG) && (iCont_X < X_END) &&
                   (iCont_Y >= Y_BEG) && (iCont_Y < Y_END);
        col_s    = 4'd0;
        row_s    = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (x_off_s >= 10'(i * TILE_W)) begin
                col_s = 4'(i);
            end else begin
                col_s = col_s;
            end
            if (y_off_s >= 10'(i * TILE_H)) begin
                row_s = 4'(i);
            end else begin
                row_s = row_s;
            end
        end
    end

    // Write port arbitration: the clear engine owns the port while clearing
    always_comb begin
        wr_ready_s = (state_q == S_IDLE) && !iClear;
        case (state_q)
            S_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_addr_q;
                wr_data_s = CLEAR_RGB;
            end
            default: begin
                wr_en_s   = iWrValid && wr_ready_s;
                wr_addr_s = iWrAddr;
                wr_data_s = iWrData;
            end
        endcase
    end

    // Stage-2 cursor hit, frame tick and output colour select
    always_comb begin
        hit_s  = (col_q == cur_x_q) && (row_q == cur_y_q);
        tick_s = vs1_q && !iV_Sync;
        if (!active_q) begin
            rgb_d = BORDER_RGB;
        end else if (hit_s && visible_q) begin
            rgb_d = CURSOR_RGB;
        end else begin
            rgb_d = tile_q;
        end
    end

    // Tile storage: single write port, contents deliberately not reset
    always_ff @(posedge Clock) begin
        if (wr_en_s) begin
            tile_mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Clear FSM: IDLE accepts writes, CLEAR sweeps addresses 0..255 once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            clr_addr_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iClear) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= 8'd0;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 8'd1;
                    if (clr_addr_q == 8'hFF) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_CLEAR;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_addr_q <= 8'd0;
                end
            endcase
        end
    end

    // Pixel pipeline, sync delay line and cursor blink timing
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            active_q  <= 1'b0;
            col_q     <= 4'd0;
            row_q     <= 4'd0;
            cur_x_q   <= 4'd0;
            cur_y_q   <= 4'd0;
            tile_q    <= 3'd0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            rgb_q     <= 3'd0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            frame_q   <= '0;
            visible_q <= 1'b1;
        end else begin
            active_q <= active_s;
            col_q    <= col_s;
            row_q    <= row_s;
            cur_x_q  <= iCursorX;
            cur_y_q  <= iCursorY;
            // Registered read port, addressed straight from stage-1 decode
            tile_q   <= tile_mem[{row_s, col_s}];
            hs1_q    <= iH_Sync;
            vs1_q    <= iV_Sync;
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            if (tick_s) begin
                if (frame_q == FC_LAST) begin
                    frame_q   <= '0;
                    visible_q <= !visible_q;
                end else begin
                    frame_q   <= frame_q + 1'b1;
                end
            end else begin
                frame_q <= frame_q;
            end
        end
    end

    assign oWrReady = wr_ready_s;
    assign oBusy    = (state_q == S_CLEAR);
    assign oRGB     = rgb_q;
    assign oH_Sync  = hs2_q;
    assign oV_Sync  = vs2_q;

endmodule

// File: tb/tb_vga_tile_painter.sv
// Self-checking bench for vga_tile_painter against a behavioural model that
// decodes tiles with plain integer division and keeps the tile map in an array.
module tb_vga_tile_painter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] iCont_X = 10'd0;
    logic [9:0] iCont_Y = 10'd0;
    logic       iH_Sync = 1'b0;
    logic       iV_Sync = 1'b0;
    logic [3:0] iCursorX = 4'd7;
    logic [3:0] iCursorY = 4'd9;
    logic       iWrValid = 1'b0;
    logic [7:0] iWrAddr = 8'd0;
    logic [2:0] iWrData = 3'd0;
    logic       oWrReady;
    logic       iClear = 1'b0;
    logic       oBusy;
    logic [2:0] oRGB;
    logic       oH_Sync;
    logic       oV_Sync;

    int checks = 0;
    int errors = 0;

    logic [2:0] tile_m [256];
    bit         vis_m = 1'b1;
    logic [2:0] exp_q [$];

    vga_tile_painter dut (
        .Clock(Clock), .Reset(Reset),
        .iCont_X(iCont_X), .iCont_Y(iCont_Y),
        .iH_Sync(iH_Sync), .iV_Sync(iV_Sync),
        .iCursorX(iCursorX), .iCursorY(iCursorY),
        .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData),
        .oWrReady(oWrReady),
        .iClear(iClear), .oBusy(oBusy),
        .oRGB(oRGB), .oH_Sync(oH_Sync), .oV_Sync(oV_Sync)
    );

    always #5 Clock = ~Clock;

    function automatic logic [2:0] model_rgb(int x, int y, int cx, int cy);
        int col;
        int row;
        if (x < 48 || x >= 48 + 16 * 40 || y < 32 || y >= 32 + 16 * 30) return 3'b010;
        col = (x - 48) / 40;
        row = (y - 32) / 30;
        if (vis_m && col == cx && row == cy) return 3'b111;
        return tile_m[row * 16 + col];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic write_tile(input logic [7:0] a, input logic [2:0] d);
        iWrValid = 1'b1;
        iWrAddr  = a;
        iWrData  = d;
        tick();
        iWrValid = 1'b0;
        tile_m[a] = d;
    endtask

    task automatic hold_pixel(input int x, input int y);
        iCont_X = 10'(x);
        iCont_Y = 10'(y);
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        iH_Sync = 1'b1;
        iCont_X = 10'd100;
        iCont_Y = 10'd100;
        tick();
        tick();
        checks++;
        if (oRGB !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b expected 000", oRGB); end
        checks++;
        if (oH_Sync !== 1'b0 || oV_Sync !== 1'b0) begin
            errors++; $display("FAIL reset_sync: got h=%b v=%b expected 0 0", oH_Sync, oV_Sync);
        end
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
        Reset = 1'b0;
        #1;
        checks++;
        if (oWrReady !== 1'b1) begin errors++; $display("FAIL reset_wrready: got %b expected 1", oWrReady); end
        iH_Sync = 1'b0;
        vis_m   = 1'b1;
    endtask

    task automatic test_clear();
        int busy_cnt;
        iWrValid = 1'b1;
        iWrAddr  = 8'h05;
        iWrData  = 3'b110;
        iClear   = 1'b1;
        #1;
        checks++;
        if (oWrReady !== 1'b0) begin errors++; $display("FAIL clear_reject: oWrReady got %b expected 0", oWrReady); end
        tick();
        iWrValid = 1'b0;
        iClear   = 1'b0;
        busy_cnt = 0;
        while (oBusy === 1'b1 && busy_cnt < 400) begin
            busy_cnt++;
            if (busy_cnt == 10) begin
                iClear = 1'b1;  // must be ignored mid-clear
                checks++;
                if (oWrReady !== 1'b0) begin errors++; $display("FAIL clear_wrready: got %b expected 0", oWrReady); end
            end else begin
                iClear = 1'b0;
            end
            tick();
        end
        iClear = 1'b0;
        checks++;
        if (busy_cnt != 256) begin errors++; $display("FAIL clear_len: got %0d busy cycles expected 256", busy_cnt); end
        checks++;
        if (oWrReady !== 1'b1) begin errors++; $display("FAIL clear_done_ready: got %b expected 1", oWrReady); end
        for (int i = 0; i < 256; i++) tile_m[i] = 3'b000;
    endtask

    task automatic test_write_pixels();
        int xs [8] = '{48, 47, 687, 688, 88, 87, 48, 48};
        int ys [8] = '{32, 32, 511, 511, 32, 32, 31, 512};
        logic [2:0] e;
        iCursorX = 4'd7;
        iCursorY = 4'd9;
        write_tile(8'h00, 3'b100);
        write_tile(8'hFF, 3'b001);
        write_tile(8'h01, 3'b011);
        for (int i = 0; i < 8; i++) begin
            hold_pixel(xs[i], ys[i]);
            e = model_rgb(xs[i], ys[i], 7, 9);
            checks++;
            if (oRGB !== e) begin
                errors++; $display("FAIL pixel_dir: x=%0d y=%0d got %b expected %b", xs[i], ys[i], oRGB, e);
            end
        end
    endtask

    // Streams one pixel per cycle; each output is checked two cycles later.
    task automatic stream_pixel(input int x, input int y, input int cx, input int cy);
        logic [2:0] e;
        iCont_X  = 10'(x);
        iCont_Y  = 10'(y);
        iCursorX = 4'(cx);
        iCursorY = 4'(cy);
        exp_q.push_back(model_rgb(x, y, cx, cy));
        tick();
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            checks++;
            if (oRGB !== e) begin errors++; $display("FAIL pixel_stream: got %b expected %b", oRGB, e); end
        end
    endtask

    task automatic flush_stream();
        logic [2:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_q.push_front(e);
            stream_pixel(0, 0, 0, 0);
            void'(exp_q.pop_back());
            if (exp_q.size() == 1) begin
                tick();
                e = exp_q.pop_front();
                checks++;
                if (oRGB !== e) begin errors++; $display("FAIL pixel_flush: got %b expected %b", oRGB, e); end
            end
        end
    endtask

    task automatic test_random_pixels();
        for (int i = 0; i < 24; i++) write_tile(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 300; i++) begin
            stream_pixel($urandom_range(0, 799), $urandom_range(0, 524),
                         $urandom_range(0, 15), $urandom_range(0, 15));
        end
        flush_stream();
    endtask

    task automatic test_cursor_blink();
        logic [2:0] e;
        write_tile(8'h23, 3'b101);
        iCursorX = 4'd3;
        iCursorY = 4'd2;
        hold_pixel(48 + 3 * 40, 32 + 2 * 30);
        checks++;
        if (oRGB !== 3'b111) begin errors++; $display("FAIL cursor_init: got %b expected 111", oRGB); end
        for (int f = 1; f <= 60; f++) begin
            iV_Sync = 1'b1;
            tick();
            tick();
            iV_Sync = 1'b0;
            tick();
            tick();
            if (f % 30 == 0) vis_m = !vis_m;
            e = model_rgb(48 + 3 * 40, 32 + 2 * 30, 3, 2);
            checks++;
            if (oRGB !== e) begin errors++; $display("FAIL cursor_blink: frame %0d got %b expected %b", f, oRGB, e); end
        end
    endtask

    task automatic test_sync_delay();
        logic [1:0] sq [$];
        logic [1:0] e;
        for (int i = 0; i < 200; i++) begin
            iH_Sync = 1'($urandom_range(0, 1));
            iV_Sync = 1'($urandom_range(0, 1));
            sq.push_back({iH_Sync, iV_Sync});
            tick();
            if (sq.size() == 2) begin
                e = sq.pop_front();
                checks++;
                if ({oH_Sync, oV_Sync} !== e) begin
                    errors++; $display("FAIL sync_delay: got %b%b expected %b", oH_Sync, oV_Sync, e);
                end
            end
        end
        iH_Sync = 1'b0;
        iV_Sync = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_during_clear();
        for (int a = 0; a < 256; a++) write_tile(8'(a), 3'($urandom_range(1, 7)));
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        repeat (100) tick();
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", oBusy); end
        Reset = 1'b1;
        #1;
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", oBusy); end
        tick();
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (oWrReady !== 1'b1) begin errors++; $display("FAIL abort_wrready: got %b expected 1", oWrReady); end
        for (int a = 0; a < 100; a++) tile_m[a] = 3'b000;
        vis_m = 1'b1;
        for (int a = 0; a < 256; a++) begin
            stream_pixel(48 + (a % 16) * 40 + $urandom_range(0, 39),
                         32 + (a / 16) * 30 + $urandom_range(0, 29), 15, 15);
        end
        flush_stream();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_pixels();
        test_random_pixels();
        test_cursor_blink();
        test_sync_delay();
        test_reset_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
